// File: rtl/square_meter.sv
// Measures high/low phase lengths of a square wave in TICK_DIV-clock units,
// reporting each completed high+low pair as a rounded (m, n) estimate.
module square_meter #(
  parameter int TICK_DIV = 10,
  parameter int W        = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sq_in,
  input  logic         clear,
  output logic [W-1:0] hi_ticks,
  output logic [W-1:0] lo_ticks,
  output logic         meas_valid,
  output logic         locked,
  output logic         overflow
);

  // state     | meaning
  // WAIT_EDGE | idle or aborted; waiting for any edge to start a phase
  // MEAS_HI   | timing a high phase
  // MEAS_LO   | timing a low phase; have_hi says a high result is pending
  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEAS_HI   = 2'd1,
    MEAS_LO   = 2'd2
  } state_t;

  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HALF1 = TICK_DIV / 2 + 1;

  // Counters restart already holding L = 1 plus the half-unit rounding offset,
  // so the unit count reads floor((L + TICK_DIV/2) / TICK_DIV) directly.
  localparam logic [PW-1:0] PRE_INIT  = (HALF1 >= TICK_DIV) ? PW'(HALF1 - TICK_DIV) : PW'(HALF1);
  localparam logic [W:0]    UNIT_INIT = (HALF1 >= TICK_DIV) ? (W+1)'(1) : '0;
  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE   = PW'(1);
  localparam logic [W:0]    UNIT_ONE  = (W+1)'(1);

  state_t         state;
  state_t         state_nxt;
  logic           s1;
  logic           s2;
  logic [PW-1:0]  prescale;
  logic [W:0]     unit_cnt;
  logic           have_hi;
  logic [W-1:0]   hi_hold;

  logic           edge_det;
  logic           ovf_hit;
  logic [W-1:0]   result;
  logic           hold_ld;
  logic           have_set;
  logic           have_clr;
  logic           strobe;
  logic           ovf_set;

  assign edge_det = s1 ^ s2;
  // Unit count reaching 2^W means the rounded result no longer fits in W bits.
  assign ovf_hit  = (state != WAIT_EDGE) && unit_cnt[W];
  assign result   = unit_cnt[W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_EDGE;
    end else if (clear) begin
      state <= WAIT_EDGE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ovf_hit) begin
      state_nxt = WAIT_EDGE;
    end else if (edge_det) begin
      case (state)
        WAIT_EDGE: state_nxt = s1 ? MEAS_HI : MEAS_LO;
        MEAS_HI:   state_nxt = MEAS_LO;
        MEAS_LO:   state_nxt = MEAS_HI;
        default:   state_nxt = WAIT_EDGE;
      endcase
    end
  end

  always_comb begin
    hold_ld  = 1'b0;
    have_set = 1'b0;
    have_clr = 1'b0;
    strobe   = 1'b0;
    ovf_set  = 1'b0;
    if (ovf_hit) begin
      ovf_set  = 1'b1;
      have_clr = 1'b1;
    end else if (edge_det) begin
      case (state)
        WAIT_EDGE: have_clr = ~s1;
        MEAS_HI: begin
          hold_ld  = 1'b1;
          have_set = 1'b1;
        end
        MEAS_LO:   strobe = have_hi;
        default:   have_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      prescale   <= '0;
      unit_cnt   <= '0;
      have_hi    <= 1'b0;
      hi_hold    <= '0;
      hi_ticks   <= '0;
      lo_ticks   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      prescale   <= '0;
      unit_cnt   <= '0;
      have_hi    <= 1'b0;
      hi_hold    <= '0;
      hi_ticks   <= '0;
      lo_ticks   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      s1 <= sq_in;
      s2 <= s1;

      if (edge_det) begin
        prescale <= PRE_INIT;
        unit_cnt <= UNIT_INIT;
      end else if (state != WAIT_EDGE) begin
        if (prescale == PRE_MAX) begin
          prescale <= '0;
          unit_cnt <= unit_cnt + UNIT_ONE;
        end else begin
          prescale <= prescale + PRE_ONE;
        end
      end

      if (hold_ld) begin
        hi_hold <= result;
      end
      if (have_set) begin
        have_hi <= 1'b1;
      end else if (have_clr) begin
        have_hi <= 1'b0;
      end

      meas_valid <= strobe;
      if (strobe) begin
        hi_ticks <= hi_hold;
        lo_ticks <= result;
      end

      if (ovf_set) begin
        overflow <= 1'b1;
        locked   <= 1'b0;
      end else if (strobe) begin
        locked <= 1'b1;
      end
    end
  end

endmodule

// File: doc/square_meter.md
# square_meter

Measures the high and low phase durations of the programmable square wave generator's output, in the same 100 ns units used for its m/n settings. It sits directly downstream of the generator's `squareOut`, in the same clock domain. It reports each completed high/low pair as an (m, n) estimate with a one-cycle valid strobe. This gives closed-loop self-check of the generator and feeds later display/compare logic.

## Interface
- `TICK_DIV`, 10: clock cycles per measurement unit (10 × 10 ns = 100 ns).
- `W`, 4: width of reported durations; matches the generator's m/n width.
- `clk`  in  1  system clock, 100 MHz, rising-edge.
- `reset`  in  1  asynchronous, active-high reset of all state.
- `sq_in`  in  1  square wave under measurement (generator `squareOut`).
- `clear`  in  1  synchronous soft clear; same effect as reset, applied on the clock edge.
- `hi_ticks`  out  W  last measured high-phase duration, rounded units.
- `lo_ticks`  out  W  last measured low-phase duration, rounded units.
- `meas_valid`  out  1  one-cycle pulse; `hi_ticks`/`lo_ticks` were updated this cycle.
- `locked`  out  1  set at the first `meas_valid`; cleared by overflow, clear or reset.
- `overflow`  out  1  sticky: a phase exceeded the representable range.

## Operation
- **Input staging:** `sq_in` passes through two registers, `s1` then `s2`.
  - Edge detect is `s1 != s2`.
  - Rising edge: `s1 = 1`. Falling edge: `s1 = 0`.
  - No internal glitch filter.
- **Phase length L:** the number of clocks between consecutive edge detects. This equals the input phase length in clocks.
- **Result R:** floor((L + TICK_DIV/2) / TICK_DIV), i.e. round half up.
  - Implement with a prescaler (0..TICK_DIV-1) plus a (W+1)-bit unit counter. Both restart at every edge detect.
  - No divider.
  - Examples with TICK_DIV = 10: L = 24 → 2; L = 25 → 3; L = 30 → 3; L < 5 → 0.
- **FSM states:** `WAIT_EDGE`, `MEAS_HI`, `MEAS_LO`, plus a `have_hi` flag and a `hi_hold` register of W bits.
- **`WAIT_EDGE`:**
  - Rising edge → `MEAS_HI`.
  - Falling edge → `MEAS_LO`, with `have_hi` = 0.
  - The partial phase before the first edge is discarded.
- **`MEAS_HI`, on falling edge:** `hi_hold` ← R, `have_hi` ← 1, go to `MEAS_LO`.
- **`MEAS_LO`, on rising edge:**
  - If `have_hi`: `hi_ticks` ← `hi_hold`, `lo_ticks` ← R, pulse `meas_valid`, set `locked`.
  - In all cases go to `MEAS_HI`.
- **Overflow:** when the running L reaches 2^W·TICK_DIV − TICK_DIV/2 (155 at the defaults), R would be ≥ 2^W. Then:
  - set `overflow`;
  - clear `locked` and `have_hi`;
  - go to `WAIT_EDGE`.
  - This also covers a DC (stuck) input.
- **Priority:** reset > clear > overflow abort > edge handling.
  - An edge coinciding with the overflow threshold is ignored.
  - An edge coinciding with `clear` is ignored.
- **Output holding:** `hi_ticks` and `lo_ticks` hold their value between strobes and are unaffected by overflow.

## Timing
- **Reset values:** `hi_ticks` = 0, `lo_ticks` = 0, `meas_valid` = 0, `locked` = 0, `overflow` = 0; `s1`, `s2` = 0; state `WAIT_EDGE`; counters 0.
- **Reset mid-measurement:** abandon everything immediately; no `meas_valid` is produced from a partial pair.
- **Latency:**
  - `sq_in` rises before clock edge k → `s1` = 1 after edge k.
  - The edge is detected in cycle k..k+1.
  - Outputs and `meas_valid` are registered at edge k+1.
- **`meas_valid`:** exactly one cycle wide. It is never asserted two cycles in a row, because every phase is at least one clock.
- **`clear`:** sampled at edge j. All reset values apply after edge j, including `overflow` = 0.
- **Strobe rate:** once `locked`, `meas_valid` fires once per input period, on the rising-edge detect.
- **Edge rate:** edges on consecutive clocks (L = 1) are legal and yield R = 0.

## Test plan
- **Nominal:** generator m = 3, n = 2, TICK_DIV = 10, reset released at the first negedge.
  - Expect `meas_valid` every 50 clocks with `hi_ticks` = 3, `lo_ticks` = 2.
  - The first strobe follows the first complete high+low pair.
  - `locked` = 1, `overflow` = 0.
- **Rounding:** drive high 24 clocks / low 25 clocks, then high 14 / low 15.
  - Expect (2, 3), then (1, 2).
- **Extremes:** drive high 150 clocks / low 1 clock.
  - Expect (15, 0) with no overflow.
  - Then drive high 155 clocks: expect `overflow` = 1 at the 155th high clock, `locked` = 0, and no strobe at the next edge.
- **DC input:** hold `sq_in` = 1 after reset.
  - Expect `overflow` = 1 once the count reaches 155 clocks after the first edge.
  - Outputs stay 0 and `meas_valid` never fires.
- **Clear/reset mid-operation:**
  - Assert `clear` during `MEAS_LO` with `have_hi` = 1: no strobe at the next rising edge, and all outputs are 0 after the clear edge.
  - Assert async `reset` between clock edges: outputs go to 0 without waiting for `clk`.
- **Re-lock:** after an overflow, restore m = 3, n = 2.
  - Expect `locked` to return at the first full pair and `overflow` to stay 1 until `clear`.
